// File: rtl/risc_toy_mem_arbiter.sv
// Arbitrates the RISC_TOY fetch and data ports onto one single-port memory,
// tagging reads so returned data is steered back to the requesting port.
module risc_toy_mem_arbiter #(
  parameter int AW       = 30,
  parameter int DW       = 32,
  parameter int RD_LAT   = 2,
  parameter int MAX_WAIT = 3
) (
  input  logic          CLK,
  input  logic          RSTN,
  input  logic          I_REQ,
  input  logic [AW-1:0] I_ADDR,
  output logic          I_GNT,
  output logic          I_RVALID,
  output logic [DW-1:0] I_RDATA,
  input  logic          D_REQ,
  input  logic          D_RW,
  input  logic [AW-1:0] D_ADDR,
  input  logic [DW-1:0] D_WDATA,
  output logic          D_GNT,
  output logic          D_RVALID,
  output logic [DW-1:0] D_RDATA,
  output logic          M_REQ,
  output logic          M_RW,
  output logic [AW-1:0] M_ADDR,
  output logic [DW-1:0] M_WDATA,
  input  logic [DW-1:0] M_RDATA
);

  typedef enum logic {PRIO_D, PRIO_I} prio_t;

  localparam logic [3:0] MAXW = 4'(MAX_WAIT);

  prio_t             state;
  logic [3:0]        i_wait;
  logic [3:0]        i_wait_nxt;
  logic              d_win;
  logic              i_win;
  logic [RD_LAT-1:0] tag_v;
  logic [RD_LAT-1:0] tag_o;
  logic              out_v;
  logic              out_o;

  // Grants are gated by RSTN so nothing reaches the memory while in reset.
  always_comb begin
    d_win = RSTN & D_REQ & ((state == PRIO_D) | ~I_REQ);
    i_win = RSTN & I_REQ & ~d_win;
  end

  always_comb begin
    if (!I_REQ || i_win)
      i_wait_nxt = '0;
    else if (i_wait == MAXW)
      i_wait_nxt = i_wait;
    else
      i_wait_nxt = i_wait + 4'd1;
  end

  assign I_GNT   = i_win;
  assign D_GNT   = d_win;
  assign M_REQ   = i_win | d_win;
  assign M_RW    = d_win & D_RW;
  assign M_ADDR  = d_win ? D_ADDR : (i_win ? I_ADDR : '0);
  assign M_WDATA = d_win ? D_WDATA : '0;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state  <= PRIO_D;
      i_wait <= '0;
      tag_v  <= '0;
      tag_o  <= '0;
    end else begin
      i_wait <= i_wait_nxt;
      case (state)
        PRIO_D: if (i_wait_nxt == MAXW) state <= PRIO_I;
        PRIO_I: if (i_win || !I_REQ) state <= PRIO_D;
        default: state <= PRIO_D;
      endcase
      tag_v[0] <= M_REQ & ~M_RW;
      tag_o[0] <= d_win;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        tag_v[i] <= tag_v[i-1];
        tag_o[i] <= tag_o[i-1];
      end
    end
  end

  assign out_v    = tag_v[RD_LAT-1];
  assign out_o    = tag_o[RD_LAT-1];
  assign D_RVALID = out_v & out_o;
  assign I_RVALID = out_v & ~out_o;
  assign D_RDATA  = D_RVALID ? M_RDATA : '0;
  assign I_RDATA  = I_RVALID ? M_RDATA : '0;

endmodule
